freq_monitor_seq: RTL
=====================

FREQ_MONITOR_SEQ -- requirements
Module: freq_monitor_seq

Interface
REQ-001 Parameter CHANNELS, default 4: number of freq_counter channels polled (1..16).
REQ-002 Parameter FC_BASEADDR, default 0: 4-byte base address of the target freq_counter.
REQ-003 Parameter POLL_DIV, default 1000000: clk cycles between sweep starts (>= 2*CHANNELS+8).
REQ-004 Parameter TIMEOUT, default 15: max clk cycles waited for m_rvalid after m_rd.
REQ-005 clk  in  1  single clock; also drives the intbus master side.
REQ-006 resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 enable  in  1  level; 1 = run sweeps, 0 = halt after current transaction.
REQ-008 thr_lo  in  24*CHANNELS  per-channel lower count bound, channel i at [24i+23:24i].
REQ-009 thr_hi  in  24*CHANNELS  per-channel upper count bound, same packing.
REQ-010 m_addr  out  32  intbus read address.
REQ-011 m_rd  out  1  one-cycle read strobe.
REQ-012 m_rdata  in  32  intbus read data.
REQ-013 m_rvalid  in  1  read data valid.
REQ-014 freq_out  out  24*CHANNELS  last captured count per channel.
REQ-015 alarm  out  CHANNELS  sticky out-of-window flag per channel.
REQ-016 sweep_done  out  1  one-cycle pulse when all channels read in a sweep.
REQ-017 err  out  2  error code: 0 none, 1 ID mismatch, 2 channel-count mismatch, 3 timeout.
REQ-018 busy  out  1  high in any state other than IDLE, WAIT, ERR.

Function
REQ-019 States SHALL be IDLE, RD_ID, RD_CHAN, WAIT, RD_FREQ, CHECK, ERR.
REQ-020 IDLE -> RD_ID when enable=1; RD_ID reads FC_BASEADDR+0, RD_CHAN reads FC_BASEADDR+1.
REQ-021 Each read: m_rd high exactly one cycle with m_addr stable; m_addr holds until m_rvalid or timeout; no new m_rd before completion.
REQ-022 RD_ID: m_rdata[15:0] != 16'h1C40 -> err=1, ERR; else RD_CHAN.
REQ-023 RD_CHAN: m_rdata != CHANNELS -> err=2, ERR; else WAIT with poll counter loaded to POLL_DIV-1.
REQ-024 WAIT: counter decrements each cycle; at 0 and enable=1 -> RD_FREQ with ch=0; at 0 and enable=0 -> IDLE.
REQ-025 RD_FREQ reads FC_BASEADDR+4+ch; on m_rvalid capture m_rdata[23:0] into freq_out[ch] and go to CHECK.
REQ-026 CHECK (1 cycle): value < thr_lo[ch] or > thr_hi[ch] (unsigned, bounds inclusive-in) sets alarm[ch]; then ch==CHANNELS-1 -> sweep_done pulse, WAIT reloaded; else ch+1, RD_FREQ.
REQ-027 Poll counter SHALL run from sweep start (entry to WAIT after RD_CHAN, then each WAIT reload), giving a sweep period of exactly POLL_DIV cycles when reads complete in 1 cycle.
REQ-028 Timeout: cycle counter starts on m_rd; reaching TIMEOUT without m_rvalid -> err=3, ERR; m_rvalid on the same cycle as timeout wins (no error).
REQ-029 m_rvalid outside an outstanding read SHALL be ignored.
REQ-030 alarm bits are sticky; cleared only by reset or by the IDLE -> RD_ID transition.
REQ-031 ERR is terminal until enable=0, which returns to IDLE and clears err to 0; err holds its code while in ERR.
REQ-032 enable falling mid-sweep: current read completes, remaining channels still read to sweep end, then IDLE (no partial sweep).
REQ-033 thr_lo > thr_hi for a channel: every value alarms; no special handling.

Reset
REQ-034 resetn=0 asynchronously: state IDLE, m_rd=0, m_addr=0, freq_out=0, alarm=0, sweep_done=0, err=0, busy=0, counters 0.
REQ-035 First transaction after resetn rises SHALL occur no earlier than the second clk edge with enable=1.

Verification
REQ-036 Model returns 0x00081C40 at base+0, 4 at base+1, counts 1000..1003, thr 900..1100, enable=1 -> four reads base+4..7, sweep_done after fourth CHECK, alarm=0, freq_out matches.
REQ-037 Channel 2 returns 1200 with thr_hi=1100 -> alarm=4'b0100, stays set in next sweep with 1000 returned.
REQ-038 base+0 returns 0x00001234 -> err=1, ERR, no base+1 read; enable=0 -> IDLE, err=0.
REQ-039 Model withholds m_rvalid on base+5 -> err=3 exactly TIMEOUT cycles after m_rd, m_rd never re-asserted.
REQ-040 POLL_DIV=40, 1-cycle responder -> consecutive sweep_done pulses exactly 40 cycles apart; enable drop during channel 1 -> sweep finishes, then IDLE.
REQ-041 resetn pulsed low during RD_FREQ with m_rvalid pending -> all outputs reset same cycle, late m_rvalid ignored.

Source files
------------

// File: rtl/freq_monitor_seq_if.sv
// ----------------------------------------------------------------------------
// freq_monitor_seq_if
// Read-only intbus link between the frequency-monitor sequencer (master) and a
// freq_counter register block (slave).
//   m_addr   : read address, held from the strobe until the read completes
//   m_rd     : one-cycle read strobe
//   m_rdata  : read data, valid while m_rvalid is high
//   m_rvalid : read data valid
// ----------------------------------------------------------------------------
interface freq_monitor_seq_if;
    logic [31:0] m_addr;
    logic        m_rd;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    modport master (
        output m_addr,
        output m_rd,
        input  m_rdata,
        input  m_rvalid
    );

    modport slave (
        input  m_addr,
        input  m_rd,
        output m_rdata,
        output m_rvalid
    );
endinterface

// File: rtl/freq_monitor_seq.sv
// ----------------------------------------------------------------------------
// freq_monitor_seq
// Sequencer that identifies a freq_counter over intbus, then periodically
// sweeps its per-channel count registers, latches the counts and raises a
// sticky alarm for any channel whose count falls outside [thr_lo, thr_hi].
//
// Ports
//   clk        : single clock, also clocks the intbus master side
//   resetn     : asynchronous active-low reset
//   enable     : 1 = run sweeps, 0 = stop at the end of the current sweep
//   thr_lo     : per-channel lower bound, channel i at [24i+23:24i]
//   thr_hi     : per-channel upper bound, same packing
//   m_bus      : intbus master (m_addr, m_rd, m_rdata, m_rvalid)
//   freq_out   : last captured count per channel
//   alarm      : sticky out-of-window flag per channel
//   sweep_done : one-cycle pulse after the last channel of a sweep is checked
//   err        : 0 none, 1 ID mismatch, 2 channel-count mismatch, 3 timeout
//   busy       : high while a read or check is in progress
// ----------------------------------------------------------------------------
module freq_monitor_seq #(
    parameter int          CHANNELS    = 4,
    parameter logic [31:0] FC_BASEADDR = 32'h0000_0000,
    parameter int          POLL_DIV    = 1000000,
    parameter int          TIMEOUT     = 15
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [24*CHANNELS-1:0]  thr_lo,
    input  logic [24*CHANNELS-1:0]  thr_hi,
    freq_monitor_seq_if.master      m_bus,
    output logic [24*CHANNELS-1:0]  freq_out,
    output logic [CHANNELS-1:0]     alarm,
    output logic                    sweep_done,
    output logic [1:0]              err,
    output logic                    busy
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [15:0]       ID_CODE   = 16'h1C40;
    localparam logic [31:0]       ID_ADDR   = FC_BASEADDR;
    localparam logic [31:0]       CHAN_ADDR = FC_BASEADDR + 32'd1;
    localparam logic [31:0]       FREQ_ADDR = FC_BASEADDR + 32'd4;
    localparam logic [31:0]       POLL_LOAD = 32'(POLL_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_CHAN,
        S_WAIT,
        S_RD_FREQ,
        S_CHECK,
        S_ERR
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_addr;
    logic                   r_rd;
    logic [TMO_W-1:0]       r_tmo;
    logic [31:0]            r_poll;
    logic [CH_W-1:0]        r_ch;
    logic [24*CHANNELS-1:0] r_freq;
    logic [CHANNELS-1:0]    r_alarm;
    logic                   r_done;
    logic [1:0]             r_err;
    logic                   r_arm;

    logic [23:0]            w_val;
    logic [23:0]            w_lo;
    logic [23:0]            w_hi;
    logic                   w_out_of_window;
    logic                   w_in_read;

    assign w_val           = r_freq[24*int'(r_ch) +: 24];
    assign w_lo            = thr_lo[24*int'(r_ch) +: 24];
    assign w_hi            = thr_hi[24*int'(r_ch) +: 24];
    assign w_out_of_window = (w_val < w_lo) || (w_val > w_hi);
    assign w_in_read       = (r_state == S_RD_ID) || (r_state == S_RD_CHAN) ||
                             (r_state == S_RD_FREQ);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_tmo   <= '0;
            r_poll  <= '0;
            r_ch    <= '0;
            r_freq  <= '0;
            r_alarm <= '0;
            r_done  <= 1'b0;
            r_err   <= 2'd0;
            r_arm   <= 1'b0;
        end else begin
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            // r_arm holds off the first read until the second edge after reset release.
            r_arm  <= 1'b1;

            // The poll counter free-runs across the whole sweep so the period
            // between sweep starts is POLL_DIV regardless of sweep length.
            if (r_poll != '0) begin
                r_poll <= r_poll - 32'd1;
            end

            // Shared timeout for every read state; a response on the
            // expiring cycle still counts as a completed read.
            if (w_in_read && !m_bus.m_rvalid) begin
                if (r_tmo == TMO_LAST) begin
                    r_tmo   <= '0;
                    r_err   <= 2'd3;
                    r_state <= S_ERR;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (enable && r_arm) begin
                        r_alarm <= '0;
                        r_rd    <= 1'b1;
                        r_addr  <= ID_ADDR;
                        r_tmo   <= '0;
                        r_state <= S_RD_ID;
                    end
                end
                S_RD_ID: begin
                    if (m_bus.m_rvalid) begin
                        r_tmo <= '0;
                        if (m_bus.m_rdata[15:0] != ID_CODE) begin
                            r_err   <= 2'd1;
                            r_state <= S_ERR;
                        end else begin
                            r_rd    <= 1'b1;
                            r_addr  <= CHAN_ADDR;
                            r_state <= S_RD_CHAN;
                        end
                    end
                end
                S_RD_CHAN: begin
                    if (m_bus.m_rvalid) begin
                        r_tmo <= '0;
                        if (m_bus.m_rdata != 32'(CHANNELS)) begin
                            r_err   <= 2'd2;
                            r_state <= S_ERR;
                        end else begin
                            r_poll  <= POLL_LOAD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_poll == '0) begin
                        if (enable) begin
                            r_ch    <= '0;
                            r_rd    <= 1'b1;
                            r_addr  <= FREQ_ADDR;
                            r_tmo   <= '0;
                            r_poll  <= POLL_LOAD;
                            r_state <= S_RD_FREQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RD_FREQ: begin
                    if (m_bus.m_rvalid) begin
                        r_tmo                      <= '0;
                        r_freq[24*int'(r_ch) +: 24] <= m_bus.m_rdata[23:0];
                        r_state                    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_out_of_window) begin
                        r_alarm[r_ch] <= 1'b1;
                    end
                    // enable is not consulted here: a started sweep always completes.
                    if (r_ch == CH_LAST) begin
                        r_done  <= 1'b1;
                        r_ch    <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= FREQ_ADDR + 32'(r_ch) + 32'd1;
                        r_tmo   <= '0;
                        r_state <= S_RD_FREQ;
                    end
                end
                S_ERR: begin
                    if (!enable) begin
                        r_err   <= 2'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_bus.m_addr = r_addr;
    assign m_bus.m_rd   = r_rd;
    assign freq_out     = r_freq;
    assign alarm        = r_alarm;
    assign sweep_done   = r_done;
    assign err          = r_err;
    assign busy         = (r_state == S_RD_ID) || (r_state == S_RD_CHAN) ||
                          (r_state == S_RD_FREQ) || (r_state == S_CHECK);

endmodule
